// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions: receive FSM states, default
// 720p timing and saturating counter helpers.
package hdmi_pkg;

    localparam int CNT_W       = 13;
    localparam int HACTIVE_DEF = 1280;
    localparam int VACTIVE_DEF = 720;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DROP   = 2'd3
    } rx_state_e;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/hdmi_rx_if.sv
// Pixel stream source bundle (no backpressure): the sink
// must accept every valid beat.
interface hdmi_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  aso_src_valid_o;
    logic [DATA_WIDTH-1:0] aso_src_data_o;
    logic                  aso_src_startofpacket_o;
    logic                  aso_src_endofpacket_o;

    modport master (
        output aso_src_valid_o,
        output aso_src_data_o,
        output aso_src_startofpacket_o,
        output aso_src_endofpacket_o
    );

    modport slave (
        input aso_src_valid_o,
        input aso_src_data_o,
        input aso_src_startofpacket_o,
        input aso_src_endofpacket_o
    );
endinterface

// File: rtl/hdmi_rx_measure.sv
// Video timing measurement: line length, line period,
// lines per frame and frame timing error flag.
module hdmi_rx_measure
    import hdmi_pkg::*;
#(
    parameter int HACTIVE = HACTIVE_DEF,
    parameter int VACTIVE = VACTIVE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic de_i,
    input  logic line_start_i,
    input  logic line_end_i,
    input  logic hs_fall_i,
    input  logic frame_start_i,
    output cnt_t h_active_o,
    output cnt_t h_total_o,
    output cnt_t v_active_o,
    output logic timing_err_o
);

    localparam cnt_t H_LIM = cnt_t'(HACTIVE);
    localparam cnt_t V_LIM = cnt_t'(VACTIVE);

    cnt_t de_len_q, de_len_d;
    cnt_t ht_cnt_q, ht_cnt_d;
    cnt_t h_active_q, h_active_d;
    cnt_t h_total_q, h_total_d;
    cnt_t lines_q, lines_d;
    cnt_t v_active_q, v_active_d;
    logic bad_q, bad_d;
    logic seen_q, seen_d;
    logic err_q, err_d;
    cnt_t lines_now;
    logic bad_now;

    // Next-state for all measurement counters and results
    always_comb begin
        de_len_d = de_len_q;
        if (line_start_i)
            de_len_d = cnt_t'(1);
        else if (de_i)
            de_len_d = sat_inc(de_len_q);
        ht_cnt_d   = hs_fall_i ? cnt_t'(1) : sat_inc(ht_cnt_q);
        h_total_d  = hs_fall_i ? ht_cnt_q : h_total_q;
        h_active_d = line_end_i ? de_len_q : h_active_q;
        lines_now  = line_end_i ? sat_inc(lines_q) : lines_q;
        bad_now    = bad_q | (line_end_i && de_len_q != H_LIM);
        lines_d    = lines_now;
        bad_d      = bad_now;
        seen_d     = seen_q;
        v_active_d = v_active_q;
        err_d      = err_q;
        if (frame_start_i) begin
            lines_d = '0;
            bad_d   = 1'b0;
            seen_d  = 1'b1;
            // the partial frame before the first frame start is not judged
            if (seen_q) begin
                v_active_d = lines_now;
                err_d      = (lines_now != V_LIM) | bad_now;
            end
        end
    end

    // Measurement state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_len_q   <= '0;
            ht_cnt_q   <= '0;
            h_active_q <= '0;
            h_total_q  <= '0;
            lines_q    <= '0;
            v_active_q <= '0;
            bad_q      <= 1'b0;
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            de_len_q   <= de_len_d;
            ht_cnt_q   <= ht_cnt_d;
            h_active_q <= h_active_d;
            h_total_q  <= h_total_d;
            lines_q    <= lines_d;
            v_active_q <= v_active_d;
            bad_q      <= bad_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
        end
    end

    assign h_active_o   = h_active_q;
    assign h_total_o    = h_total_q;
    assign v_active_o   = v_active_q;
    assign timing_err_o = err_q;

endmodule

// File: rtl/hdmi_rx.sv
// HDMI receiver front end: frame capture FSM and pixel
// stream output with two-cycle pin-to-output latency.
module hdmi_rx
    import hdmi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HACTIVE    = HACTIVE_DEF,
    parameter int VACTIVE    = VACTIVE_DEF
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       data_enable,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] data_r,
    input  logic [7:0] data_g,
    input  logic [7:0] data_b,
    input  logic       capture_en,
    hdmi_rx_if.master  src,
    output logic       frame_active_o,
    output cnt_t       h_active_o,
    output cnt_t       h_total_o,
    output cnt_t       v_active_o,
    output logic       timing_err_o
);

    localparam cnt_t H_LIM = cnt_t'(HACTIVE);
    localparam cnt_t V_LIM = cnt_t'(VACTIVE);

    logic de_q, hs_q, vs_q, cap_q;
    logic de_p_q, hs_p_q, vs_p_q;
    logic [23:0] pix_q;
    rx_state_e state_q, state_d;
    cnt_t pix_cnt_q, pix_cnt_d;
    cnt_t line_cnt_q, line_cnt_d;
    cnt_t pix_idx;
    logic frame_start, line_start, line_end, hs_fall;
    logic in_win, last_pix;
    logic valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Register pins once; keep a second copy for edge detection
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            de_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            cap_q  <= 1'b0;
            de_p_q <= 1'b0;
            hs_p_q <= 1'b0;
            vs_p_q <= 1'b0;
            pix_q  <= '0;
        end else begin
            de_q   <= data_enable;
            hs_q   <= hsync;
            vs_q   <= vsync;
            cap_q  <= capture_en;
            de_p_q <= de_q;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            pix_q  <= {data_b, data_g, data_r};
        end
    end

    assign frame_start = vs_p_q & ~vs_q;
    assign line_start  = de_q & ~de_p_q;
    assign line_end    = ~de_q & de_p_q;
    assign hs_fall     = hs_p_q & ~hs_q;

    // Pixel/line position of the sample currently in stage 1
    always_comb begin
        pix_idx   = line_start ? '0 : pix_cnt_q;
        pix_cnt_d = pix_cnt_q;
        if (line_start)
            pix_cnt_d = cnt_t'(1);
        else if (de_q)
            pix_cnt_d = sat_inc(pix_cnt_q);
        line_cnt_d = line_cnt_q;
        if (frame_start)
            line_cnt_d = '0;
        else if (line_end)
            line_cnt_d = sat_inc(line_cnt_q);
        // frame start wins over a coincident pixel
        in_win   = de_q & ~frame_start & (pix_idx < H_LIM);
        last_pix = (pix_idx == H_LIM - 1) && (line_cnt_q == V_LIM - 1);
    end

    // State and position counters
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SEEK;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Next-state: capture_en only matters at frame start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARMED:  if (in_win) state_d = ST_STREAM;
            ST_STREAM: if (in_win && last_pix) state_d = ST_DROP;
            default:   state_d = state_q;
        endcase
        if (frame_start)
            state_d = cap_q ? ST_ARMED : ST_DROP;
    end

    // Output beat decode for the stage-1 sample
    always_comb begin
        valid_d = in_win && (state_q == ST_ARMED || state_q == ST_STREAM);
        sop_d   = in_win && (state_q == ST_ARMED);
        eop_d   = valid_d && last_pix;
        data_d  = '0;
        if (valid_d)
            data_d[23:0] = pix_q;
    end

    // Output register
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
        end
    end

    assign src.aso_src_valid_o         = valid_q;
    assign src.aso_src_data_o          = data_q;
    assign src.aso_src_startofpacket_o = sop_q;
    assign src.aso_src_endofpacket_o   = eop_q;
    assign frame_active_o = (state_q == ST_ARMED) || (state_q == ST_STREAM);

    hdmi_rx_measure #(
        .HACTIVE(HACTIVE),
        .VACTIVE(VACTIVE)
    ) u_measure (
        .clk          (pixel_clk),
        .rst          (reset),
        .de_i         (de_q),
        .line_start_i (line_start),
        .line_end_i   (line_end),
        .hs_fall_i    (hs_fall),
        .frame_start_i(frame_start),
        .h_active_o   (h_active_o),
        .h_total_o    (h_total_o),
        .v_active_o   (v_active_o),
        .timing_err_o (timing_err_o)
    );

endmodule

// File: tb/tb_hdmi_rx.sv
// Directed testbench for hdmi_rx with an 8x4 active frame
// plus 720p line timing and saturation measurements.
module tb_hdmi_rx;

    localparam int HA = 8;
    localparam int VA = 4;

    logic clk = 1'b0;
    logic rst, de, hs, vs, cap;
    logic [7:0] dr, dg, db;
    logic fa, terr;
    logic [12:0] hact, htot, vact;

    hdmi_rx_if #(.DATA_WIDTH(32)) src ();

    hdmi_rx #(.DATA_WIDTH(32), .HACTIVE(HA), .VACTIVE(VA)) dut (
        .pixel_clk(clk), .reset(rst), .data_enable(de),
        .hsync(hs), .vsync(vs), .data_r(dr), .data_g(dg),
        .data_b(db), .capture_en(cap), .src(src.master),
        .frame_active_o(fa), .h_active_o(hact), .h_total_o(htot),
        .v_active_o(vact), .timing_err_o(terr)
    );

    always #5 clk = ~clk;

    int asserts = 0;
    int fails = 0;
    int cyc = 0;
    int line0_cyc = 0;
    int beats = 0;
    int sop_n = 0;
    int eop_n = 0;
    int sop_at = -1;
    int eop_at = -1;
    logic [31:0] got[$];
    int gcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (src.aso_src_valid_o === 1'b1) begin
            got.push_back(src.aso_src_data_o);
            gcyc.push_back(cyc);
            if (src.aso_src_startofpacket_o === 1'b1) begin
                sop_n  <= sop_n + 1;
                sop_at <= beats;
            end
            if (src.aso_src_endofpacket_o === 1'b1) begin
                eop_n  <= eop_n + 1;
                eop_at <= beats;
            end
            beats <= beats + 1;
        end
    end

    function automatic logic [31:0] px(input int ln, input int p);
        logic [7:0] r;
        r = 8'(((ln % 16) * 16) + (p % 16));
        return {8'h00, ~r, r + 8'h33, r};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync_pulse(input logic c);
        @(negedge clk);
        cap = c;
        vs = 1'b0;
        tick(1);
        @(negedge clk);
        vs = 1'b1;
        tick(3);
    endtask

    task automatic drive_line(input int len, input int ln, input int tail);
        logic [31:0] w;
        @(negedge clk);
        hs = 1'b0;
        tick(1);
        @(negedge clk);
        hs = 1'b1;
        tick(2);
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            w = px(ln, p);
            de = 1'b1;
            dr = w[7:0];
            dg = w[15:8];
            db = w[23:16];
            if (ln == 0 && p == 0) line0_cyc = cyc;
        end
        @(negedge clk);
        de = 1'b0;
        tick(tail - 1);
    endtask

    task automatic frame(input int n, input int badln, input int badlen);
        for (int ln = 0; ln < n; ln++)
            drive_line((ln == badln) ? badlen : HA, ln, 3);
    endtask

    task automatic check_data(input string nm, input int b0, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++)
            if (got[b0 + k] !== px(k / HA, k % HA)) bad++;
        asserts++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d wrong pixels, want 0", nm, bad);
        end
    endtask

    task automatic test_reset;
        tick(3);
        asserts++;
        if ({src.aso_src_valid_o, src.aso_src_startofpacket_o,
             src.aso_src_endofpacket_o, fa, terr} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0", {src.aso_src_valid_o,
                src.aso_src_startofpacket_o, src.aso_src_endofpacket_o, fa, terr});
        end
        asserts++;
        if ({src.aso_src_data_o, hact, htot, vact} !== '0) begin
            fails++;
            $display("FAIL reset_values: data %h hact %0d htot %0d vact %0d want 0",
                src.aso_src_data_o, hact, htot, vact);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        asserts++;
        if (fa !== 1'b0 || beats !== 0) begin
            fails++;
            $display("FAIL reset_idle: fa %b beats %0d want 0 0", fa, beats);
        end
    endtask

    task automatic test_clean_frame;
        int b0, s0, e0;
        b0 = beats; s0 = sop_n; e0 = eop_n;
        vsync_pulse(1'b1);
        asserts++;
        if (fa !== 1'b1 || terr !== 1'b0 || vact !== 13'd0) begin
            fails++;
            $display("FAIL clean_armed: fa %b err %b vact %0d want 1 0 0", fa, terr, vact);
        end
        frame(VA, -1, 0);
        tick(4);
        asserts++;
        if (beats - b0 !== 32) begin
            fails++;
            $display("FAIL clean_beats: got %0d want 32", beats - b0);
        end
        asserts++;
        if (sop_n - s0 !== 1 || sop_at !== b0) begin
            fails++;
            $display("FAIL clean_sop: n %0d at %0d want 1 at %0d", sop_n - s0, sop_at, b0);
        end
        asserts++;
        if (eop_n - e0 !== 1 || eop_at !== b0 + 31) begin
            fails++;
            $display("FAIL clean_eop: n %0d at %0d want 1 at %0d", eop_n - e0, eop_at, b0 + 31);
        end
        asserts++;
        if (gcyc[b0] - line0_cyc !== 2) begin
            fails++;
            $display("FAIL clean_latency: got %0d want 2", gcyc[b0] - line0_cyc);
        end
        check_data("clean_data", b0, 32);
        asserts++;
        if (fa !== 1'b0) begin
            fails++;
            $display("FAIL clean_after_eop_fa: got %b want 0", fa);
        end
        vsync_pulse(1'b0);
        asserts++;
        if (vact !== 13'd4 || terr !== 1'b0) begin
            fails++;
            $display("FAIL clean_meas: vact %0d err %b want 4 0", vact, terr);
        end
        asserts++;
        if (hact !== 13'd8 || htot !== 13'd16) begin
            fails++;
            $display("FAIL clean_h: hact %0d htot %0d want 8 16", hact, htot);
        end
    endtask

    task automatic test_capture_late;
        int b0, s0;
        b0 = beats;
        vsync_pulse(1'b0);
        frame(2, -1, 0);
        cap = 1'b1;
        frame(2, -1, 0);
        tick(4);
        asserts++;
        if (beats - b0 !== 0 || fa !== 1'b0) begin
            fails++;
            $display("FAIL late_dropped: beats %0d fa %b want 0 0", beats - b0, fa);
        end
        b0 = beats; s0 = sop_n;
        vsync_pulse(1'b1);
        frame(VA, -1, 0);
        tick(4);
        asserts++;
        if (beats - b0 !== 32 || sop_n - s0 !== 1 || sop_at !== b0) begin
            fails++;
            $display("FAIL late_next: beats %0d sop %0d at %0d want 32 1 %0d",
                beats - b0, sop_n - s0, sop_at, b0);
        end
        vsync_pulse(1'b0);
        asserts++;
        if (vact !== 13'd4 || terr !== 1'b0) begin
            fails++;
            $display("FAIL late_meas: vact %0d err %b want 4 0", vact, terr);
        end
    endtask

    task automatic test_long_line;
        int b0, e0;
        b0 = beats; e0 = eop_n;
        vsync_pulse(1'b1);
        frame(2, -1, 0);
        drive_line(10, 2, 3);
        tick(2);
        asserts++;
        if (hact !== 13'd10) begin
            fails++;
            $display("FAIL long_hact: got %0d want 10", hact);
        end
        drive_line(HA, 3, 3);
        tick(4);
        asserts++;
        if (beats - b0 !== 32 || eop_n - e0 !== 1 || eop_at !== b0 + 31) begin
            fails++;
            $display("FAIL long_beats: beats %0d eop %0d at %0d want 32 1 %0d",
                beats - b0, eop_n - e0, eop_at, b0 + 31);
        end
        check_data("long_data", b0, 32);
        vsync_pulse(1'b0);
        asserts++;
        if (vact !== 13'd4 || terr !== 1'b1) begin
            fails++;
            $display("FAIL long_err: vact %0d err %b want 4 1", vact, terr);
        end
    endtask

    task automatic test_short_frame;
        int b0, e0, s1;
        b0 = beats; e0 = eop_n;
        vsync_pulse(1'b1);
        frame(3, -1, 0);
        tick(4);
        asserts++;
        if (beats - b0 !== 24) begin
            fails++;
            $display("FAIL short_beats: got %0d want 24", beats - b0);
        end
        vsync_pulse(1'b1);
        asserts++;
        if (eop_n - e0 !== 0 || vact !== 13'd3 || terr !== 1'b1) begin
            fails++;
            $display("FAIL short_meas: eop %0d vact %0d err %b want 0 3 1",
                eop_n - e0, vact, terr);
        end
        b0 = beats; s1 = sop_n;
        drive_line(HA, 0, 3);
        tick(4);
        asserts++;
        if (beats - b0 !== 8 || sop_n - s1 !== 1 || sop_at !== b0 || fa !== 1'b1) begin
            fails++;
            $display("FAIL short_next_sop: beats %0d sop %0d at %0d fa %b want 8 1 %0d 1",
                beats - b0, sop_n - s1, sop_at, fa, b0);
        end
        vsync_pulse(1'b0);
    endtask

    task automatic test_reset_mid_frame;
        int b0, e0, s0;
        b0 = beats; e0 = eop_n;
        vsync_pulse(1'b1);
        fork
            frame(VA, -1, 0);
            begin
                int i;
                i = 0;
                while ((beats - b0) < 12 && i < 2000) begin
                    @(posedge clk);
                    i++;
                end
                asserts++;
                if ((beats - b0) < 12) begin
                    fails++;
                    $display("FAIL rst_wait: beats %0d want 12", beats - b0);
                end else begin
                    #1 rst = 1'b1;
                    #1;
                    asserts++;
                    if ({src.aso_src_valid_o, src.aso_src_startofpacket_o,
                         src.aso_src_endofpacket_o, fa, terr} !== 5'b0 ||
                        {src.aso_src_data_o, hact, htot, vact} !== '0) begin
                        fails++;
                        $display("FAIL rst_outputs: valid %b fa %b data %h hact %0d want 0",
                            src.aso_src_valid_o, fa, src.aso_src_data_o, hact);
                    end
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
        join
        tick(4);
        asserts++;
        if (beats - b0 !== 12 || eop_n - e0 !== 0 || fa !== 1'b0) begin
            fails++;
            $display("FAIL rst_abort: beats %0d eop %0d fa %b want 12 0 0",
                beats - b0, eop_n - e0, fa);
        end
        b0 = beats; s0 = sop_n; e0 = eop_n;
        vsync_pulse(1'b1);
        frame(VA, -1, 0);
        tick(4);
        asserts++;
        if (beats - b0 !== 32 || sop_at !== b0 || sop_n - s0 !== 1 || eop_n - e0 !== 1) begin
            fails++;
            $display("FAIL rst_resume: beats %0d sop %0d at %0d eop %0d want 32 1 %0d 1",
                beats - b0, sop_n - s0, sop_at, eop_n - e0, b0);
        end
        check_data("rst_resume_data", b0, 32);
        vsync_pulse(1'b0);
        asserts++;
        if (vact !== 13'd4 || terr !== 1'b0) begin
            fails++;
            $display("FAIL rst_meas: vact %0d err %b want 4 0", vact, terr);
        end
    endtask

    task automatic test_measure;
        int b0;
        b0 = beats;
        vsync_pulse(1'b0);
        for (int l = 0; l < 3; l++) drive_line(1280, l, 365);
        tick(3);
        asserts++;
        if (htot !== 13'd1650 || hact !== 13'd1280) begin
            fails++;
            $display("FAIL meas_720p: htot %0d hact %0d want 1650 1280", htot, hact);
        end
        drive_line(8200, 3, 3);
        tick(2);
        asserts++;
        if (hact !== 13'd8191) begin
            fails++;
            $display("FAIL meas_hact_sat: got %0d want 8191", hact);
        end
        drive_line(HA, 4, 3);
        tick(2);
        asserts++;
        if (htot !== 13'd8191) begin
            fails++;
            $display("FAIL meas_htot_sat: got %0d want 8191", htot);
        end
        vsync_pulse(1'b0);
        asserts++;
        if (vact !== 13'd5 || terr !== 1'b1 || beats - b0 !== 0) begin
            fails++;
            $display("FAIL meas_frame: vact %0d err %b beats %0d want 5 1 0",
                vact, terr, beats - b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        de = 1'b0; hs = 1'b1; vs = 1'b1; cap = 1'b0;
        dr = '0; dg = '0; db = '0;
        test_reset();
        test_clean_frame();
        test_capture_late();
        test_long_line();
        test_short_frame();
        test_reset_mid_frame();
        test_measure();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
